// File: rtl/bomb_game_ctrl.sv
// Round sequencer and round-robin strike arbiter in front of the extras timer/strike bus.
// Bus outputs and flags are decoded from the state register; strikes commit at most one per two cycles.
module bomb_game_ctrl #(
  parameter int NUM_MODULES   = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int START_SECONDS = 300,
  parameter int MAX_STRIKES   = 3,
  parameter logic [ADDR_WIDTH-1:0] TIMER_ADDR  = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] STRIKE_ADDR = 16'h0400
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [NUM_MODULES-1:0] strike_req,
  input  logic [NUM_MODULES-1:0] solved,
  input  logic [DATA_WIDTH-1:0]  mem_q,
  output logic [DATA_WIDTH-1:0]  mem_data,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_we,
  output logic                   mem_en,
  output logic [NUM_MODULES-1:0] strike_ack,
  output logic [1:0]             strikes,
  output logic [2:0]             state,
  output logic                   defused,
  output logic                   exploded
);

  localparam int PW = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLEAR     = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_STRIKE_WR = 3'd4;
  localparam logic [2:0] S_DEFUSED   = 3'd5;
  localparam logic [2:0] S_EXPLODED  = 3'd6;

  localparam logic [1:0]             MAX_S = 2'(MAX_STRIKES);
  localparam logic [NUM_MODULES-1:0] ONE   = {{(NUM_MODULES-1){1'b0}}, 1'b1};

  logic [NUM_MODULES-1:0] pending;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          sel_q;
  logic [PW-1:0]          sel;
  logic                   found;
  logic                   prev_load;
  logic                   timer_zero;
  logic                   all_solved;

  assign timer_zero = (mem_q == '0);
  assign all_solved = &solved;

  // First pending index at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_MODULES; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_MODULES;
      if (!found && pending[PW'(idx)]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      strikes   <= 2'd0;
      pending   <= '0;
      rr_ptr    <= '0;
      sel_q     <= '0;
      prev_load <= 1'b0;
    end else begin
      prev_load <= (state == S_LOAD);
      if (start && state != S_CLEAR && state != S_LOAD) begin
        state   <= S_CLEAR;
        strikes <= 2'd0;
        pending <= '0;
        rr_ptr  <= '0;
      end else begin
        case (state)
          S_CLEAR: state <= S_LOAD;
          S_LOAD:  state <= S_RUN;
          S_RUN: begin
            // Expiry is ignored on the first read: the timer was loaded one cycle ago.
            if (timer_zero && !prev_load) begin
              state   <= S_EXPLODED;
              pending <= '0;
            end else if (found) begin
              pending <= (pending & ~(ONE << sel)) | strike_req;
              rr_ptr  <= PW'((int'(sel) + 1) % NUM_MODULES);
              sel_q   <= sel;
              if (strikes < MAX_S) strikes <= strikes + 2'd1;
              state   <= S_STRIKE_WR;
            end else if (all_solved) begin
              state   <= S_DEFUSED;
              pending <= '0;
            end else begin
              pending <= pending | strike_req;
            end
          end
          S_STRIKE_WR: begin
            if (strikes >= MAX_S) begin
              state   <= S_EXPLODED;
              pending <= '0;
            end else begin
              state   <= S_RUN;
              pending <= pending | strike_req;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    case (state)
      S_CLEAR: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = STRIKE_ADDR;
      end
      S_LOAD: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = TIMER_ADDR;
        mem_data = DATA_WIDTH'(START_SECONDS);
      end
      S_RUN: begin
        mem_en   = 1'b1;
        mem_addr = TIMER_ADDR;
      end
      S_STRIKE_WR: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = STRIKE_ADDR;
        mem_data = DATA_WIDTH'(strikes);
      end
      default: ;
    endcase
  end

  assign strike_ack = (state == S_STRIKE_WR) ? (ONE << sel_q) : '0;
  assign defused    = (state == S_DEFUSED);
  assign exploded   = (state == S_EXPLODED);

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Directed vector table plus randomized run against a behavioural round model.
module tb_bomb_game_ctrl;
  localparam int N     = 4;
  localparam int MAXS  = 3;
  localparam int START = 300;

  logic        clk = 1'b0;
  logic        resetn, start;
  logic [3:0]  strike_req, solved;
  logic [15:0] mem_q, mem_data, mem_addr;
  logic        mem_we, mem_en;
  logic [3:0]  strike_ack;
  logic [1:0]  strikes;
  logic [2:0]  state;
  logic        defused, exploded;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bomb_game_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .strike_req(strike_req),
    .solved(solved), .mem_q(mem_q), .mem_data(mem_data), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_en(mem_en), .strike_ack(strike_ack), .strikes(strikes),
    .state(state), .defused(defused), .exploded(exploded)
  );

  typedef struct {
    bit        rn;
    bit        st;
    bit [3:0]  req;
    bit [3:0]  sol;
    bit [15:0] q;
    int        e_state;
    int        e_strikes;
    bit [3:0]  e_ack;
  } vec_t;

  vec_t vt[$];

  task automatic add(bit rn, bit st, bit [3:0] req, bit [3:0] sol, bit [15:0] q,
                     int es, int ek, bit [3:0] ea);
    vec_t v;
    v.rn = rn; v.st = st; v.req = req; v.sol = sol; v.q = q;
    v.e_state = es; v.e_strikes = ek; v.e_ack = ea;
    vt.push_back(v);
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected extras bus {en, we, addr, data} for a given phase and strike count.
  function automatic logic [33:0] bus_exp(int s, int k);
    case (s)
      1: return {1'b1, 1'b1, 16'h0400, 16'd0};
      2: return {1'b1, 1'b1, 16'h0000, 16'(START)};
      3: return {1'b1, 1'b0, 16'h0000, 16'd0};
      4: return {1'b1, 1'b1, 16'h0400, 16'(k)};
      default: return 34'd0;
    endcase
  endfunction

  task automatic check_all(string tag, int es, int ek, bit [3:0] ea);
    check({tag, ".state"},    64'(state),      64'(es));
    check({tag, ".strikes"},  64'(strikes),    64'(ek));
    check({tag, ".ack"},      64'(strike_ack), 64'(ea));
    check({tag, ".flags"},    64'({defused, exploded}), 64'({es == 5, es == 6}));
    check({tag, ".bus"},      64'({mem_en, mem_we, mem_addr, mem_data}), 64'(bus_exp(es, ek)));
  endtask

  task automatic drive(bit rn, bit st, bit [3:0] req, bit [3:0] sol, bit [15:0] q);
    resetn = rn; start = st; strike_req = req; solved = sol; mem_q = q;
  endtask

  // Behavioural model: phase numbers follow the state output encoding.
  int m_phase, m_strikes, m_ptr, m_sel;
  bit m_pend[N];
  bit m_after_load;

  task automatic model_clear_pend();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_latch(bit [3:0] req);
    for (int i = 0; i < N; i++) if (req[i]) m_pend[i] = 1'b1;
  endtask

  task automatic model_step(bit rn, bit st, bit [3:0] req, bit [3:0] sol, bit [15:0] q);
    bit nxt_after_load;
    int npend;
    nxt_after_load = (m_phase == 2);
    npend = 0;
    for (int i = 0; i < N; i++) npend += int'(m_pend[i]);
    if (!rn) begin
      m_phase = 0; m_strikes = 0; m_ptr = 0; m_sel = 0;
      model_clear_pend();
      nxt_after_load = 1'b0;
    end else if (st && m_phase != 1 && m_phase != 2) begin
      m_phase = 1; m_strikes = 0; m_ptr = 0;
      model_clear_pend();
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 3;
    end else if (m_phase == 3) begin
      if (q == 16'd0 && !m_after_load) begin
        m_phase = 6;
        model_clear_pend();
      end else if (npend > 0) begin
        int k;
        k = m_ptr;
        while (!m_pend[k]) k = (k + 1) % N;
        m_sel = k;
        m_pend[k] = 1'b0;
        model_latch(req);
        m_ptr = (k + 1) % N;
        m_strikes = m_strikes + 1;
        m_phase = 4;
      end else if (sol == 4'hF) begin
        m_phase = 5;
        model_clear_pend();
      end else begin
        model_latch(req);
      end
    end else if (m_phase == 4) begin
      if (m_strikes >= MAXS) begin
        m_phase = 6;
        model_clear_pend();
      end else begin
        m_phase = 3;
        model_latch(req);
      end
    end
    m_after_load = nxt_after_load;
  endtask

  initial begin
    bit rn, st;
    bit [3:0] req, sol;
    bit [15:0] q;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 16'd300);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_all("reset", 0, 0, 4'h0);
    @(posedge clk); #1;

    //   rn st  req    sol    q       state strikes ack
    add(1, 1, 4'h0, 4'h0, 16'd300, 0, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd300, 1, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd300, 2, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd0,   3, 0, 4'h0);
    add(1, 0, 4'h4, 4'h0, 16'd299, 3, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd299, 3, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd298, 4, 1, 4'h4);
    add(1, 0, 4'hB, 4'h0, 16'd298, 3, 1, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd297, 3, 1, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd297, 4, 2, 4'h8);
    add(1, 0, 4'h0, 4'h0, 16'd296, 3, 2, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd296, 4, 3, 4'h1);
    add(1, 0, 4'h0, 4'h0, 16'd295, 6, 3, 4'h0);
    add(1, 0, 4'h1, 4'h0, 16'd295, 6, 3, 4'h0);
    add(1, 1, 4'h0, 4'h0, 16'd295, 6, 3, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd300, 1, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd300, 2, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd300, 3, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd0,   3, 0, 4'h0);
    add(1, 1, 4'h0, 4'h0, 16'd0,   6, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd300, 1, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd300, 2, 0, 4'h0);
    add(1, 0, 4'h2, 4'h0, 16'd300, 3, 0, 4'h0);
    add(1, 0, 4'h0, 4'hF, 16'd299, 3, 0, 4'h0);
    add(1, 0, 4'h0, 4'hF, 16'd299, 4, 1, 4'h2);
    add(1, 0, 4'h0, 4'hF, 16'd298, 3, 1, 4'h0);
    add(1, 0, 4'hF, 4'hF, 16'd298, 5, 1, 4'h0);
    add(1, 0, 4'hF, 4'hF, 16'd297, 5, 1, 4'h0);
    add(1, 1, 4'h0, 4'h0, 16'd297, 5, 1, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd300, 1, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd300, 2, 0, 4'h0);
    add(1, 0, 4'h1, 4'h0, 16'd300, 3, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd299, 3, 0, 4'h0);
    add(0, 0, 4'h0, 4'h0, 16'd299, 4, 1, 4'h1);
    add(1, 0, 4'hF, 4'h0, 16'd299, 0, 0, 4'h0);
    add(1, 0, 4'h0, 4'h0, 16'd299, 0, 0, 4'h0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rn, vt[i].st, vt[i].req, vt[i].sol, vt[i].q);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vt[i].e_state, vt[i].e_strikes, vt[i].e_ack);
      @(posedge clk); #1;
    end

    // Randomized run against the model, starting from a fresh reset.
    drive(1'b0, 1'b0, 4'h0, 4'h0, 16'd300);
    model_step(1'b0, 1'b0, 4'h0, 4'h0, 16'd300);
    @(posedge clk); #1;
    sol = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      rn  = ($urandom_range(0, 299) != 0);
      st  = ($urandom_range(0, 29) == 0);
      req = 4'h0;
      for (int b = 0; b < N; b++) req[b] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) sol = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      q = ($urandom_range(0, 49) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      drive(rn, st, req, sol, q);
      @(negedge clk);
      check_all($sformatf("rnd%0d", c), m_phase, m_strikes,
                (m_phase == 4) ? 4'(1 << m_sel) : 4'h0);
      model_step(rn, st, req, sol, q);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bomb_game_ctrl.md
# bomb_game_ctrl

Game sequencer and strike arbiter for the bomb. It sits between the puzzle modules and the extras memory-mapped block (countdown timer at the timer address, strike LEDs at the strike address). It starts a round by clearing strikes and loading the countdown, then polls the timer. It serialises strike requests from all puzzle modules onto the single extras write port using round-robin order, and declares the round DEFUSED or EXPLODED.

## Interface
- NUM_MODULES, 4, number of puzzle modules (2..8)
- DATA_WIDTH, 16, extras bus data width
- ADDR_WIDTH, 16, extras bus address width
- START_SECONDS, 300, countdown loaded at round start (legal range 1..65535)
- MAX_STRIKES, 3, strike count that explodes the bomb (1..3)
- TIMER_ADDR, 16'h0000, extras address of timer (bit 10 = 0)
- STRIKE_ADDR, 16'h0400, extras address of strike register (bit 10 = 1)

- clk  in  1  single system clock, all logic rising-edge
- resetn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins or restarts a round
- strike_req  in  NUM_MODULES  one-cycle strike pulse per module
- solved  in  NUM_MODULES  level, module i puzzle complete
- mem_q  in  DATA_WIDTH  extras read data (combinational from mem_addr)
- mem_data  out  DATA_WIDTH  extras write data
- mem_addr  out  ADDR_WIDTH  extras address
- mem_we  out  1  extras write enable
- mem_en  out  1  extras access enable
- strike_ack  out  NUM_MODULES  one-hot pulse, strike of module i committed
- strikes  out  2  current strike count
- state  out  3  IDLE=0, CLEAR=1, LOAD=2, RUN=3, STRIKE_WR=4, DEFUSED=5, EXPLODED=6
- defused  out  1  high while in DEFUSED
- exploded  out  1  high while in EXPLODED

## Operation
- Reset (resetn=0 at edge): state=IDLE, strikes=0, pending=0, rr_ptr=0, strike_ack=0, defused=exploded=0. Reset mid-round aborts immediately with no bus write.
- Bus outputs are decoded from the state register only. In states with no access: mem_en=0, mem_we=0, mem_addr=0, mem_data=0.
  - CLEAR: write 0 to STRIKE_ADDR.
  - LOAD: write START_SECONDS to TIMER_ADDR.
  - RUN: read TIMER_ADDR (mem_en=1, mem_we=0).
  - STRIKE_WR: write zero-extended strikes to STRIKE_ADDR.
- IDLE: wait for start. strike_req is ignored.
- start in any state except CLEAR or LOAD goes to CLEAR; strikes and pending are cleared, rr_ptr=0. CLEAR->LOAD->RUN unconditionally.
- pending[i] is set by strike_req[i] in RUN and STRIKE_WR. If the set and clear of the same bit fall in the same cycle, the set wins and a second strike stays pending. strike_req in other states is dropped.
- RUN priority, evaluated each cycle:
  1. mem_q==0 and the previous state was not LOAD -> EXPLODED.
  2. Else if pending!=0: select the first pending index at or after rr_ptr, wrapping. Clear that bit, set rr_ptr=sel+1 mod NUM_MODULES, set strikes=strikes+1, go to STRIKE_WR.
  3. Else if solved is all ones -> DEFUSED.
  4. Else stay in RUN.
- STRIKE_WR: strike_ack[sel]=1 for this cycle only. Next state is EXPLODED if strikes>=MAX_STRIKES, else RUN.
- Strikes from already-solved modules still count. strikes never exceeds MAX_STRIKES.
- Entering DEFUSED or EXPLODED clears pending. Both states are terminal until start or reset. The extras timer is not stopped by this block.

## Timing
- start sampled at edge 0: CLEAR in cycle 1, LOAD in cycle 2, first RUN read in cycle 3. The expiry check is suppressed in cycle 3 because the timer has just been loaded.
- Strike latency, for a strike_req at cycle t in RUN with no other pending work:
  - pending bit set at t+1;
  - STRIKE_WR, strike_ack and the bus write at t+2;
  - strikes output updated at t+2;
  - back in RUN at t+3.
- Throughput: one committed strike per 2 cycles. N simultaneous requests drain in 2N cycles in round-robin order.
- defused and exploded assert in the first cycle of their state. strike_ack is never high outside STRIKE_WR.

## Test plan
- Reset then start: bus shows write 0@0x0400, then write 300@0x0000, then continuous reads @0x0000; state sequence 1,2,3; strikes=0.
- Single strike from module 2 in RUN: strike_ack=4'b0100 exactly 2 cycles later; write 1@0x0400; strikes=1; back to RUN.
- strike_req=4'b1011 in one cycle with rr_ptr=1: acks in order 0010, 1000, 0001, each 2 cycles apart. The third strike raises strikes to 3, MAX_STRIKES is reached, state goes to EXPLODED and exploded=1.
- mem_q forced to 0 in RUN (not the first RUN cycle): EXPLODED next cycle. mem_q=0 in the first RUN cycle after LOAD is ignored.
- solved=4'b1111 with a strike pending in the same cycle: the strike is committed first (STRIKE_WR), then DEFUSED. A strike_req in DEFUSED is ignored and strikes is unchanged.
- resetn low during STRIKE_WR: next cycle state=IDLE, strikes=0, strike_ack=0, mem_en=0. A start from EXPLODED restarts the round at CLEAR with strikes=0.
